// File: rtl/mux_sel_pipe.sv
// Registered N:1 operand select with valid/ready handshake.
// Two-entry skid storage; illegal selects replay the last legal word.
module mux_sel_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 3,
  parameter  int ERR_W  = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ERR_W-1:0]        err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] out_reg;
  logic             out_err;
  logic [WIDTH-1:0] skid_reg;
  logic             skid_err;
  logic             ready_reg;
  logic [WIDTH-1:0] word;
  logic             word_err;
  logic             accept;
  logic             deliver;

  assign accept      = in_valid && ready_reg;
  assign deliver     = out_valid && out_ready;
  assign in_ready    = ready_reg;
  assign out_valid   = (state != EMPTY);
  assign out_data    = out_reg;
  assign out_sel_err = out_err;

  // Decode select: only in-range codes match, anything else replays hold_reg
  always_comb begin
    word     = hold_reg;
    word_err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        word     = in_data[k*WIDTH +: WIDTH];
        word_err = 1'b0;
      end
    end
  end

  // Track last legal word and count accepted illegal selects (saturating)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg  <= '0;
      err_count <= '0;
    end else if (accept) begin
      if (!word_err) begin
        hold_reg <= word;
      end else if (err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  // Output/skid occupancy state machine with registered in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_reg   <= '0;
      out_err   <= 1'b0;
      skid_reg  <= '0;
      skid_err  <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            out_reg <= word;
            out_err <= word_err;
            state   <= ONE;
          end
        end
        ONE: begin
          if (deliver && accept) begin
            out_reg <= word;
            out_err <= word_err;
          end else if (deliver) begin
            state <= EMPTY;
          end else if (accept) begin
            skid_reg  <= word;
            skid_err  <= word_err;
            ready_reg <= 1'b0;
            state     <= FULL;
          end
        end
        FULL: begin
          if (deliver) begin
            out_reg   <= skid_reg;
            out_err   <= skid_err;
            ready_reg <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe: default, narrow-counter
// and 8-bit/5-input instances.
module tb_mux_sel_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // instance a: defaults
  logic [95:0] a_data;
  logic [1:0]  a_sel;
  logic        a_valid, a_ready, a_oerr, a_ovalid, a_ordy;
  logic [31:0] a_odata;
  logic [7:0]  a_cnt;

  // instance b: ERR_W = 2
  logic [95:0] b_data;
  logic [1:0]  b_sel;
  logic        b_valid, b_ready, b_oerr, b_ovalid, b_ordy;
  logic [31:0] b_odata;
  logic [1:0]  b_cnt;

  // instance c: WIDTH = 8, NUM_IN = 5
  logic [39:0] c_data;
  logic [2:0]  c_sel;
  logic        c_valid, c_ready, c_oerr, c_ovalid, c_ordy;
  logic [7:0]  c_odata;
  logic [7:0]  c_cnt;

  mux_sel_pipe u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel),
    .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata),
    .out_sel_err(a_oerr), .out_valid(a_ovalid), .out_ready(a_ordy),
    .err_count(a_cnt)
  );

  mux_sel_pipe #(.ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel),
    .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata),
    .out_sel_err(b_oerr), .out_valid(b_ovalid), .out_ready(b_ordy),
    .err_count(b_cnt)
  );

  mux_sel_pipe #(.WIDTH(8), .NUM_IN(5)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_sel(c_sel),
    .in_valid(c_valid), .in_ready(c_ready), .out_data(c_odata),
    .out_sel_err(c_oerr), .out_valid(c_ovalid), .out_ready(c_ordy),
    .err_count(c_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    c_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_ovalid, a_ready, a_oerr} !== 3'b010) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 010",
               {a_ovalid, a_ready, a_oerr});
    end
    n_cmp++;
    if (a_odata !== 32'h0 || a_cnt !== 8'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%h want 0/0", a_odata, a_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h11};
    logic [1:0]  sels  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    a_data = {32'h33, 32'h22, 32'h11};
    a_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_sel   = sels[i];
      tick();
      n_cmp++;
      if (a_odata !== exp_d[i] || a_ovalid !== 1'b1 || a_oerr !== 1'b0) begin
        n_bad++;
        $display("FAIL stream%0d: got %h v%b e%b want %h v1 e0",
                 i, a_odata, a_ovalid, a_oerr, exp_d[i]);
      end
      @(negedge clk);
    end
    a_valid = 1'b0;
    tick();
    n_cmp++;
    if (a_ovalid !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_drain: got valid %b want 0", a_ovalid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    a_ordy  = 1'b1;
    a_data  = {32'h3, 32'hAAAA_0001, 32'h1};
    a_valid = 1'b1;
    a_sel   = 2'd3;
    tick();
    n_cmp++;
    if (a_odata !== 32'h0 || a_oerr !== 1'b1 || a_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL illegal_first: got %h e%b c%0d want 0 e1 c1",
               a_odata, a_oerr, a_cnt);
    end
    do_reset();
    a_valid = 1'b1;
    a_sel   = 2'd1;
    tick();
    n_cmp++;
    if (a_odata !== 32'hAAAA_0001 || a_oerr !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_legal: got %h e%b want aaaa0001 e0",
               a_odata, a_oerr);
    end
    @(negedge clk);
    a_sel  = 2'd3;
    a_data = {32'h3, 32'h5555_5555, 32'h1};
    tick();
    n_cmp++;
    if (a_odata !== 32'hAAAA_0001 || a_oerr !== 1'b1 || a_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL illegal_hold: got %h e%b c%0d want aaaa0001 e1 c1",
               a_odata, a_oerr, a_cnt);
    end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    a_ordy  = 1'b0;
    a_sel   = 2'd0;
    a_valid = 1'b1;
    a_data  = {32'h0, 32'h0, 32'h100};
    tick();
    n_cmp++;
    if (a_odata !== 32'h100 || a_ovalid !== 1'b1 || a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_w0: got %h v%b r%b want 100 v1 r1",
               a_odata, a_ovalid, a_ready);
    end
    @(negedge clk);
    a_data = {32'h0, 32'h0, 32'h101};
    tick();
    n_cmp++;
    if (a_odata !== 32'h100 || a_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_full: got %h r%b want 100 r0", a_odata, a_ready);
    end
    @(negedge clk);
    a_data = {32'h0, 32'h0, 32'h102};
    tick();
    n_cmp++;
    if (a_odata !== 32'h100 || a_ready !== 1'b0 || a_ovalid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stall: got %h r%b v%b want 100 r0 v1",
               a_odata, a_ready, a_ovalid);
    end
    @(negedge clk);
    a_ordy = 1'b1;
    tick();
    n_cmp++;
    if (a_odata !== 32'h101 || a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_w1: got %h r%b want 101 r1", a_odata, a_ready);
    end
    tick();
    n_cmp++;
    if (a_odata !== 32'h102 || a_ovalid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_w2: got %h v%b want 102 v1", a_odata, a_ovalid);
    end
    @(negedge clk);
    a_valid = 1'b0;
    tick();
    n_cmp++;
    if (a_ovalid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drain: got valid %b want 0", a_ovalid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_ordy  = 1'b0;
    a_valid = 1'b1;
    a_sel   = 2'd3;
    tick();
    @(negedge clk);
    a_sel  = 2'd2;
    a_data = {32'h77, 32'h0, 32'h0};
    tick();
    n_cmp++;
    if (a_ready !== 1'b0 || a_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL mid_full: got r%b c%0d want r0 c1", a_ready, a_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (a_ovalid !== 1'b0 || a_ready !== 1'b1 || a_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got v%b r%b c%0d want v0 r1 c0",
               a_ovalid, a_ready, a_cnt);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    a_ordy = 1'b1;
    a_data = {32'h55, 32'h0, 32'h0};
    tick();
    n_cmp++;
    if (a_odata !== 32'h55 || a_ovalid !== 1'b1 || a_oerr !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_first: got %h v%b e%b want 55 v1 e0",
               a_odata, a_ovalid, a_oerr);
    end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    b_ordy  = 1'b1;
    b_data  = {32'h3, 32'h2, 32'h1};
    b_sel   = 2'd3;
    b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (b_cnt !== exp_c[i] || b_oerr !== 1'b1) begin
        n_bad++;
        $display("FAIL sat%0d: got c%0d e%b want c%0d e1",
                 i, b_cnt, b_oerr, exp_c[i]);
      end
    end
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic test_param();
    logic [2:0] sels  [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [7:0] exp_d [5] = '{8'h14, 8'h14, 8'h14, 8'h14, 8'h10};
    logic       exp_e [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    c_ordy  = 1'b1;
    c_data  = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    c_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c_sel = sels[i];
      tick();
      n_cmp++;
      if (c_odata !== exp_d[i] || c_oerr !== exp_e[i]) begin
        n_bad++;
        $display("FAIL param%0d: got %h e%b want %h e%b",
                 i, c_odata, c_oerr, exp_d[i], exp_e[i]);
      end
      @(negedge clk);
    end
    c_valid = 1'b0;
    n_cmp++;
    if (c_cnt !== 8'd3) begin
      n_bad++;
      $display("FAIL param_cnt: got %0d want 3", c_cnt);
    end
  endtask

  initial begin
    a_data = '0; a_sel = '0; a_valid = 1'b0; a_ordy = 1'b1;
    b_data = '0; b_sel = '0; b_valid = 1'b0; b_ordy = 1'b1;
    c_data = '0; c_sel = '0; c_valid = 1'b0; c_ordy = 1'b1;
    test_reset();
    test_stream();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Parametrised, registered N:1 operand-select stage for the KGP-RISC datapath. It generalises the fixed 32-bit 3:1 select to any width and input count, and adds a valid/ready handshake with a 2-entry skid buffer so it can sit between pipeline stages. Illegal select codes hold the last legally selected value instead of inferring a latch. They are flagged per transfer and counted.

## Interface
- WIDTH, 32, data width of every input and the output
- NUM_IN, 3, number of data inputs (>= 2)
- ERR_W, 8, width of the saturating illegal-select counter
- SEL_W (localparam), $clog2(NUM_IN), select width

- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  NUM_IN*WIDTH  flattened inputs; input k = in_data[k*WIDTH +: WIDTH]
- in_sel  in  SEL_W  index of input to pass
- in_valid  in  1  upstream offers in_data/in_sel
- in_ready  out  1  stage can accept this cycle
- out_data  out  WIDTH  selected, registered data
- out_sel_err  out  1  this output word came from an illegal select
- out_valid  out  1  out_data/out_sel_err valid
- out_ready  in  1  downstream accepts this cycle
- err_count  out  ERR_W  illegal selects accepted since reset, saturating

## Operation
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- Legal select (in_sel < NUM_IN): word = input[in_sel], err = 0, and hold_reg <= input[in_sel].
- Illegal select (in_sel >= NUM_IN): word = hold_reg, err = 1, and hold_reg is unchanged.
- hold_reg resets to 0, so an illegal first select yields 0 with err = 1.
- err_count increments on each accepted illegal select. It saturates at 2^ERR_W-1 and never wraps.
- Storage is an output register (O) plus a skid register (S). The state machine has three states:
  - EMPTY: O invalid, S invalid. Accept -> word to O -> ONE.
  - ONE: O valid, S invalid.
    - Deliver and accept -> O <= word, stay ONE.
    - Deliver only -> EMPTY.
    - Accept only -> S <= word -> FULL.
  - FULL: O valid, S valid. in_ready = 0, so no accept is possible. Deliver -> O <= S -> ONE.
- in_ready = (state != FULL) and is driven from a register (no in->out combinational path).
- out_valid = (state != EMPTY).
- Delivery order equals acceptance order; no word is dropped or duplicated.
- in_data and in_sel are ignored when there is no accept. The select is decoded only at accept.
- When out_valid = 1 and out_ready = 0, out_data and out_sel_err are held stable.

## Timing
- Latency: 1 cycle. A word accepted at edge t appears on out_data with out_valid = 1 after edge t.
- Throughput: 1 word/cycle while out_ready = 1.
- in_ready falls one cycle after the 2nd word is accepted with out_ready low. It rises the cycle after the FULL-state delivery.
- Reset (async assert, any state, including mid-transfer):
  - state = EMPTY.
  - out_valid = 0, out_data = 0, out_sel_err = 0.
  - in_ready = 1, err_count = 0, hold_reg = 0.
  - The contents of S are discarded.
- Release is synchronous to clk. The first accept is possible on the first edge after rst_n rises.
- Simultaneous accept and deliver in ONE: no bubble; O is replaced by the new word on the same edge.

## Test plan
- Reset mid-stream: rst_n low in FULL -> outputs immediately out_valid=0, in_ready=1, err_count=0. After release, the first accepted word appears 1 cycle later.
- Streaming, defaults: out_ready=1, sels 0,1,2,0 with inputs 0x11/0x22/0x33 -> out_data 0x11,0x22,0x33,0x11 on consecutive cycles, each with out_sel_err=0.
- Illegal hold: sel=1 (in1=0xAAAA_0001), then sel=3 -> out_data 0xAAAA_0001 twice, out_sel_err 0 then 1, err_count=1. An illegal sel straight after reset -> 0x0, err=1.
- Backpressure: out_ready=0, three back-to-back in_valid words W0/W1/W2 -> W0 and W1 accepted, in_ready=0, W2 stalled. Raise out_ready -> W0, W1, W2 delivered in order, no loss.
- Saturation: ERR_W=2, five accepted illegal selects -> err_count reads 1,2,3,3,3.
- Parametrisation: WIDTH=8, NUM_IN=5 (SEL_W=3) -> sel 4 selects input 4; sels 5,6,7 are flagged illegal and output hold_reg.
